if_id_buffer: RTL and testbench

Pipeline register between the instruction fetch stage and the decode stage. It is a 2-entry skid buffer with valid/ready handshakes on both sides, so that fetch and decode can stall independently without combinational ready paths. It captures each fetched instruction with its PC and presents the held instruction, PC+4, and pre-split MIPS fields to decode. A synchronous flush squashes everything held, for taken branches and jumps.

---
 rtl/if_id_buffer.sv | 139 +++++++++++++
 tb/tb_if_id_buffer.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/if_id_buffer.sv
// -----------------------------------------------------------------------------
// if_id_buffer
//   IF/ID pipeline register built as a 2-entry skid buffer. Both handshakes
//   are registered-ready, so fetch and decode can stall independently with no
//   combinational path from out_ready to in_ready. The held instruction is
//   presented with its PC, PC+4 and the pre-split MIPS fields. A synchronous
//   flush squashes every held entry.
//
//   state | meaning
//   ------+-----------------------------------------------------------
//   EMPTY | nothing held, out_valid = 0
//   ONE   | main register holds the oldest entry, skid register unused
//   FULL  | main holds the oldest entry, skid holds the next; in_ready = 0
//
// Ports
//   clk              rising-edge clock
//   reset            asynchronous reset, active low
//   in_valid/ready   fetch-side handshake
//   in_instr, in_pc  fetched instruction and its address
//   flush            synchronous squash of all held entries
//   out_valid/ready  decode-side handshake
//   out_instr/pc     held instruction and its address
//   out_pc_plus4     out_pc + 4 (wraps)
//   opcode..funct    MIPS field split of out_instr
//   imm_sext         sign-extended out_instr[15:0]
//   delivered_count  number of completed output handshakes (wraps)
// -----------------------------------------------------------------------------
module if_id_buffer #(
  parameter int ADDR_W  = 32,
  parameter int INSTR_W = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [INSTR_W-1:0] in_instr,
  input  logic [ADDR_W-1:0]  in_pc,
  input  logic               flush,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [INSTR_W-1:0] out_instr,
  output logic [ADDR_W-1:0]  out_pc,
  output logic [ADDR_W-1:0]  out_pc_plus4,
  output logic [5:0]         opcode,
  output logic [4:0]         rs,
  output logic [4:0]         rt,
  output logic [4:0]         rd,
  output logic [4:0]         shamt,
  output logic [5:0]         funct,
  output logic [31:0]        imm_sext,
  output logic [31:0]        delivered_count
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t             state;
  logic [INSTR_W-1:0] main_instr;
  logic [ADDR_W-1:0]  main_pc;
  logic [INSTR_W-1:0] skid_instr;
  logic [ADDR_W-1:0]  skid_pc;

  logic in_fire;
  logic out_fire;

  // Both readies come straight from the state register.
  assign in_ready  = (state != FULL);
  assign out_valid = (state != EMPTY);

  assign in_fire  = in_valid & in_ready;
  assign out_fire = out_valid & out_ready;

  assign out_instr    = main_instr;
  assign out_pc       = main_pc;
  assign out_pc_plus4 = main_pc + ADDR_W'(4);

  assign opcode   = main_instr[31:26];
  assign rs       = main_instr[25:21];
  assign rt       = main_instr[20:16];
  assign rd       = main_instr[15:11];
  assign shamt    = main_instr[10:6];
  assign funct    = main_instr[5:0];
  assign imm_sext = {{16{main_instr[15]}}, main_instr[15:0]};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state           <= EMPTY;
      main_instr      <= '0;
      main_pc         <= '0;
      skid_instr      <= '0;
      skid_pc         <= '0;
      delivered_count <= '0;
    end else begin
      // A handshake completed in a flush cycle still counts as delivered.
      if (out_fire) begin
        delivered_count <= delivered_count + 32'd1;
      end

      if (flush) begin
        // Only the state is squashed; stale data stays in the registers.
        state <= EMPTY;
      end else begin
        case (state)
          EMPTY: begin
            if (in_fire) begin
              main_instr <= in_instr;
              main_pc    <= in_pc;
              state      <= ONE;
            end
          end
          ONE: begin
            if (in_fire && out_fire) begin
              main_instr <= in_instr;
              main_pc    <= in_pc;
            end else if (in_fire) begin
              skid_instr <= in_instr;
              skid_pc    <= in_pc;
              state      <= FULL;
            end else if (out_fire) begin
              state <= EMPTY;
            end
          end
          FULL: begin
            if (out_fire) begin
              main_instr <= skid_instr;
              main_pc    <= skid_pc;
              state      <= ONE;
            end
          end
          default: state <= EMPTY;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_if_id_buffer.sv
// -----------------------------------------------------------------------------
// tb_if_id_buffer
//   Directed bench for if_id_buffer. Accepted inputs are pushed into an
//   expected-queue; a monitor pops and compares on every output handshake.
//   Flush and reset empty the queue the same way they empty the buffer.
// -----------------------------------------------------------------------------
module tb_if_id_buffer;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_instr;
  logic [31:0] in_pc;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic [31:0] out_pc_plus4;
  logic [5:0]  opcode;
  logic [4:0]  rs;
  logic [4:0]  rt;
  logic [4:0]  rd;
  logic [4:0]  shamt;
  logic [5:0]  funct;
  logic [31:0] imm_sext;
  logic [31:0] delivered_count;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } ent_t;

  ent_t exp_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  if_id_buffer #(.ADDR_W(32), .INSTR_W(32)) dut (
    .clk             (clk),
    .reset           (reset),
    .in_valid        (in_valid),
    .in_ready        (in_ready),
    .in_instr        (in_instr),
    .in_pc           (in_pc),
    .flush           (flush),
    .out_valid       (out_valid),
    .out_ready       (out_ready),
    .out_instr       (out_instr),
    .out_pc          (out_pc),
    .out_pc_plus4    (out_pc_plus4),
    .opcode          (opcode),
    .rs              (rs),
    .rt              (rt),
    .rd              (rd),
    .shamt           (shamt),
    .funct           (funct),
    .imm_sext        (imm_sext),
    .delivered_count (delivered_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  // Scoreboard monitor: samples on the falling edge, i.e. the values that the
  // next rising edge will act on.
  always @(negedge clk) begin
    if (reset) begin
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_out", out_pc, 32'hDEAD_DEAD);
        end else begin
          ent_t e;
          e = exp_q.pop_front();
          chk("sb_instr", out_instr, e.instr);
          chk("sb_pc", out_pc, e.pc);
          chk("sb_pc_plus4", out_pc_plus4, e.pc + 32'd4);
        end
      end
      if (flush) exp_q.delete();
      else if (in_valid && in_ready) exp_q.push_back('{instr: in_instr, pc: in_pc});
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic offer(input logic [31:0] instr, input logic [31:0] pc);
    in_valid = 1'b1;
    in_instr = instr;
    in_pc    = pc;
  endtask

  initial begin
    reset     = 1'b0;
    in_valid  = 1'b0;
    in_instr  = '0;
    in_pc     = '0;
    flush     = 1'b0;
    out_ready = 1'b0;

    #12;
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_out_instr", out_instr, 32'h0);
    chk("rst_out_pc", out_pc, 32'h0);
    chk("rst_count", delivered_count, 32'd0);
    reset = 1'b1;

    // Streaming with out_ready held high.
    tick();
    out_ready = 1'b1;
    offer(32'h2008_0005, 32'h0);
    tick();
    chk("s1_valid", {31'd0, out_valid}, 32'd1);
    chk("s1_pc", out_pc, 32'h0);
    chk("s1_pc4", out_pc_plus4, 32'h4);
    offer(32'h2009_0003, 32'h4);
    tick();
    chk("s2_pc", out_pc, 32'h4);
    chk("s2_pc4", out_pc_plus4, 32'h8);
    offer(32'h0109_5020, 32'h8);
    tick();
    chk("s3_pc", out_pc, 32'h8);
    chk("s3_pc4", out_pc_plus4, 32'hC);
    in_valid = 1'b0;
    tick();
    chk("s_count", delivered_count, 32'd3);
    chk("s_empty", {31'd0, out_valid}, 32'd0);

    // Back-pressure: two accepted, third held by fetch.
    out_ready = 1'b0;
    offer(32'h1111_0001, 32'h100);
    tick();
    chk("bp_ready1", {31'd0, in_ready}, 32'd1);
    offer(32'h1111_0002, 32'h104);
    tick();
    chk("bp_ready_full", {31'd0, in_ready}, 32'd0);
    chk("bp_head", out_pc, 32'h100);
    offer(32'h1111_0003, 32'h108);
    tick();
    chk("bp_still_full", {31'd0, in_ready}, 32'd0);
    out_ready = 1'b1;
    tick();
    chk("bp_ready_rise", {31'd0, in_ready}, 32'd1);
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    chk("bp_count", delivered_count, 32'd6);
    chk("bp_empty", {31'd0, out_valid}, 32'd0);

    // Flush while FULL, with an offered input.
    out_ready = 1'b0;
    offer(32'h2222_0001, 32'h200);
    tick();
    offer(32'h2222_0002, 32'h204);
    tick();
    chk("fl_full", {31'd0, in_ready}, 32'd0);
    offer(32'h2222_0003, 32'h208);
    flush = 1'b1;
    tick();
    flush    = 1'b0;
    in_valid = 1'b0;
    chk("fl_valid", {31'd0, out_valid}, 32'd0);
    chk("fl_ready", {31'd0, in_ready}, 32'd1);
    chk("fl_count", delivered_count, 32'd6);

    // Flush in ONE with output handshake and accepted input in the same cycle.
    offer(32'h3333_0001, 32'h300);
    tick();
    offer(32'h3333_0002, 32'h304);
    out_ready = 1'b1;
    flush     = 1'b1;
    tick();
    flush    = 1'b0;
    in_valid = 1'b0;
    chk("fl2_valid", {31'd0, out_valid}, 32'd0);
    chk("fl2_count", delivered_count, 32'd7);
    tick();
    tick();
    chk("fl2_nothing", {31'd0, out_valid}, 32'd0);

    // Field decode.
    out_ready = 1'b0;
    offer(32'h8D28_FFFC, 32'h400);
    tick();
    in_valid = 1'b0;
    chk("dec_opcode", {26'd0, opcode}, 32'h23);
    chk("dec_rs", {27'd0, rs}, 32'd9);
    chk("dec_rt", {27'd0, rt}, 32'd8);
    chk("dec_imm", imm_sext, 32'hFFFF_FFFC);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    offer(32'h000A_4940, 32'h404);
    tick();
    in_valid = 1'b0;
    chk("dec_shamt", {27'd0, shamt}, 32'd5);
    chk("dec_funct", {26'd0, funct}, 32'd0);
    chk("dec_rd", {27'd0, rd}, 32'd9);
    chk("dec_imm_pos", imm_sext, 32'h0000_4940);
    out_ready = 1'b1;
    tick();
    chk("dec_count", delivered_count, 32'd9);

    // PC wrap and counter wrap.
    out_ready = 1'b0;
    offer(32'h0000_1234, 32'hFFFF_FFFC);
    tick();
    in_valid = 1'b0;
    chk("pc4_wrap", out_pc_plus4, 32'h0);
    force dut.delivered_count = 32'hFFFF_FFFF;
    #1;
    release dut.delivered_count;
    chk("cnt_preload", delivered_count, 32'hFFFF_FFFF);
    out_ready = 1'b1;
    tick();
    chk("cnt_wrap", delivered_count, 32'h0);
    chk("wrap_empty", {31'd0, out_valid}, 32'd0);

    // Asynchronous reset with two entries held.
    out_ready = 1'b0;
    offer(32'h4444_0001, 32'h500);
    tick();
    offer(32'h4444_0002, 32'h504);
    tick();
    in_valid = 1'b0;
    chk("ar_full", {31'd0, in_ready}, 32'd0);
    #1;
    reset = 1'b0;
    #1;
    chk("ar_valid", {31'd0, out_valid}, 32'd0);
    chk("ar_instr", out_instr, 32'h0);
    chk("ar_ready", {31'd0, in_ready}, 32'd1);
    exp_q.delete();
    #3;
    reset = 1'b1;
    tick();
    chk("ar_after_valid", {31'd0, out_valid}, 32'd0);
    chk("ar_after_count", delivered_count, 32'd0);

    // Transfers resume after reset.
    out_ready = 1'b1;
    offer(32'h5555_0001, 32'h600);
    tick();
    in_valid = 1'b0;
    chk("rs_valid", {31'd0, out_valid}, 32'd1);
    chk("rs_pc", out_pc, 32'h600);
    tick();
    chk("rs_count", delivered_count, 32'd1);
    tick();
    chk("sb_drained", exp_q.size(), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
